// File: rtl/ds_mem_pkg.sv
// Shared definitions for the DS-form load/store address-generation stage:
// memOp encodings, FSM state type, latched-op payload and the legality check.
package ds_mem_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned IMM_W   = 14;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned MEMOP_W = 3;

  // memOp = {isStore, XO[30:31]}
  localparam logic [MEMOP_W-1:0] MEMOP_LD   = 3'b000;
  localparam logic [MEMOP_W-1:0] MEMOP_LDU  = 3'b001;
  localparam logic [MEMOP_W-1:0] MEMOP_LWA  = 3'b010;
  localparam logic [MEMOP_W-1:0] MEMOP_STD  = 3'b100;
  localparam logic [MEMOP_W-1:0] MEMOP_STDU = 3'b101;
  localparam logic [MEMOP_W-1:0] MEMOP_STQ  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_VALID = 2'd2
  } agen_state_e;

  // Decoded fields captured at accept and consumed in the READ cycle.
  typedef struct packed {
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   ra;
    logic               base_zero;
    logic [IMM_W-1:0]   imm;
    logic [MEMOP_W-1:0] mem_op;
  } ds_op_t;

  // XO=3 is reserved; update forms need a real RA; load-update may not target RA.
  function automatic logic op_legal(input logic [MEMOP_W-1:0] mem_op,
                                    input logic [REG_W-1:0]   rt,
                                    input logic [REG_W-1:0]   ra);
    logic [1:0] xo;
    xo = mem_op[1:0];
    if (xo == 2'b11) return 1'b0;
    if ((xo == 2'b01) && (ra == '0)) return 1'b0;
    if ((xo == 2'b01) && !mem_op[2] && (ra == rt)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/ds_ea_calc.sv
// Effective-address adder for DS-form ops: ea = base + signext({imm, 2'b00}).
// Optional alignment check is built only when DS_AGEN_ALIGN_CHECK_EN is defined.
module ds_ea_calc
  import ds_mem_pkg::*;
(
  input  logic [XLEN-1:0]    base,
  input  logic [IMM_W-1:0]   imm,
  input  logic [MEMOP_W-1:0] mem_op,
  output logic [XLEN-1:0]    ea,
  output logic               align_fault
);

  logic [XLEN-1:0] disp;

  // Word-scaled displacement, sign-extended; the add wraps modulo 2^64.
  always_comb begin
    disp = {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    ea   = base + disp;
  end

`ifdef DS_AGEN_ALIGN_CHECK_EN
  // Quadword store needs 16-byte alignment; every other op needs 8-byte alignment.
  always_comb begin
    align_fault = 1'b0;
    if (mem_op == MEMOP_STQ) align_fault = (ea[3:0] != 4'd0);
    else                     align_fault = (ea[2:0] != 3'd0);
  end
`else
  logic unused_mem_op;

  // No check logic: the fault flag is tied low.
  always_comb begin
    unused_mem_op = ^mem_op;
    align_fault   = 1'b0;
  end
`endif

endmodule

// File: rtl/ds_agen_stage.sv
// DS-form address-generation stage: accept a decoded op, read RA from the
// register file, add the scaled displacement and present the EA downstream.
// Alignment checking is enabled by defining DS_AGEN_ALIGN_CHECK_EN.
module ds_agen_stage
  import ds_mem_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               enable_i,
  output logic               ready_o,
  input  logic [REG_W-1:0]   reg1_i,
  input  logic [REG_W-1:0]   reg2_i,
  input  logic               reg2ValOrZero_i,
  input  logic [IMM_W-1:0]   imm_i,
  input  logic [MEMOP_W-1:0] memOp_i,
  output logic               regReadEn_o,
  output logic [REG_W-1:0]   regReadAddr_o,
  input  logic [XLEN-1:0]    regReadData_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [XLEN-1:0]    addr_o,
  output logic [REG_W-1:0]   rt_o,
  output logic [MEMOP_W-1:0] memOp_o,
  output logic               updateEn_o,
  output logic [REG_W-1:0]   updateReg_o,
  output logic               alignFault_o,
  output logic               err_o
);

  agen_state_e     state_q, state_d;
  ds_op_t          op_q;
  logic            accept, legal, take, read_needed;
  logic [XLEN-1:0] base, ea;
  logic            align_fault;

  // Handshake and register-file request; the read is issued in the accept cycle
  // so the data lands in READ. Gated by reset so nothing leaks out during reset.
  always_comb begin
    ready_o       = reset_n_i && ((state_q == ST_IDLE) || ((state_q == ST_VALID) && ready_i));
    accept        = enable_i && ready_o;
    legal         = op_legal(memOp_i, reg1_i, reg2_i);
    take          = accept && legal;
    read_needed   = !(reg2ValOrZero_i && (reg2_i == '0));
    regReadEn_o   = take && read_needed;
    regReadAddr_o = regReadEn_o ? reg2_i : '0;
  end

  // State register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state; illegal ops are consumed without leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (take) state_d = ST_READ;
      ST_READ:  state_d = ST_VALID;
      ST_VALID: if (ready_i) state_d = take ? ST_READ : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture decoded fields of a legal op at accept.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      op_q <= '0;
    end else if (take) begin
      op_q <= '{rt: reg1_i, ra: reg2_i,
                base_zero: reg2ValOrZero_i && (reg2_i == '0),
                imm: imm_i, mem_op: memOp_i};
    end
  end

  // RA==0 with the zero flag means a literal zero base.
  always_comb base = op_q.base_zero ? '0 : regReadData_i;

  ds_ea_calc u_ea_calc (
    .base        (base),
    .imm         (op_q.imm),
    .mem_op      (op_q.mem_op),
    .ea          (ea),
    .align_fault (align_fault)
  );

  // Output registers: load at end of READ, hold while stalled, drop on handshake.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_o      <= 1'b0;
      addr_o       <= '0;
      rt_o         <= '0;
      memOp_o      <= '0;
      updateEn_o   <= 1'b0;
      updateReg_o  <= '0;
      alignFault_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      err_o <= accept && !legal;
      if (state_q == ST_READ) begin
        valid_o      <= 1'b1;
        addr_o       <= ea;
        rt_o         <= op_q.rt;
        memOp_o      <= op_q.mem_op;
        updateEn_o   <= (op_q.mem_op[1:0] == 2'b01);
        updateReg_o  <= (op_q.mem_op[1:0] == 2'b01) ? op_q.ra : '0;
        alignFault_o <= align_fault;
      end else if ((state_q == ST_VALID) && ready_i) begin
        valid_o      <= 1'b0;
        alignFault_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ds_agen_stage.sv
// Directed bench for ds_agen_stage; alignment expectations follow DS_AGEN_ALIGN_CHECK_EN.
module tb_ds_agen_stage;
  import ds_mem_pkg::*;

`ifdef DS_AGEN_ALIGN_CHECK_EN
  localparam logic ALIGN = 1'b1;
`else
  localparam logic ALIGN = 1'b0;
`endif

  logic        clock_i, reset_n_i, enable_i, ready_o;
  logic [4:0]  reg1_i, reg2_i;
  logic        reg2ValOrZero_i;
  logic [13:0] imm_i;
  logic [2:0]  memOp_i;
  logic        regReadEn_o;
  logic [4:0]  regReadAddr_o;
  logic [63:0] regReadData_i;
  logic        valid_o, ready_i;
  logic [63:0] addr_o;
  logic [4:0]  rt_o;
  logic [2:0]  memOp_o;
  logic        updateEn_o;
  logic [4:0]  updateReg_o;
  logic        alignFault_o, err_o;

  logic [63:0] rf [0:31];
  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  int hs_cnt = 0;
  int base_cnt;

  ds_agen_stage dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .enable_i(enable_i), .ready_o(ready_o),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .reg2ValOrZero_i(reg2ValOrZero_i), .imm_i(imm_i),
    .memOp_i(memOp_i), .regReadEn_o(regReadEn_o), .regReadAddr_o(regReadAddr_o),
    .regReadData_i(regReadData_i), .valid_o(valid_o), .ready_i(ready_i), .addr_o(addr_o),
    .rt_o(rt_o), .memOp_o(memOp_o), .updateEn_o(updateEn_o), .updateReg_o(updateReg_o),
    .alignFault_o(alignFault_o), .err_o(err_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // Register-file model: data is returned the cycle after the read enable.
  always @(posedge clock_i) begin
    if (regReadEn_o) regReadData_i <= rf[regReadAddr_o];
  end

  // Event counters.
  always @(posedge clock_i) begin
    if (regReadEn_o) rd_cnt <= rd_cnt + 1;
    if (err_o) err_cnt <= err_cnt + 1;
    if (reset_n_i && valid_o && ready_i) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [2:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic rz, input logic [13:0] imm);
    enable_i = en; memOp_i = op; reg1_i = r1; reg2_i = r2;
    reg2ValOrZero_i = rz; imm_i = imm;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 5'd0, 5'd0, 1'b0, 14'd0);
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'h0;
    rf[0] = 64'h0000_0000_0000_DEAD;
    rf[3] = 64'h0000_0000_0000_1000;
    rf[5] = 64'hFFFF_FFFF_FFFF_FFF8;
    reset_n_i = 1'b0;
    ready_i   = 1'b1;
    enable_i = 1'b0; memOp_i = 3'b000; reg1_i = 5'd0; reg2_i = 5'd0;
    reg2ValOrZero_i = 1'b0; imm_i = 14'd0;

    // Reset state
    repeat (2) @(posedge clock_i);
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_rden", 64'(regReadEn_o), 64'd0);
    chk("rst_addr", addr_o, 64'd0);
    chk("rst_upd", 64'(updateEn_o), 64'd0);
    reset_n_i = 1'b1;
    #1;
    chk("rst_ready", 64'(ready_o), 64'd1);

    // LD RA=3 (0x1000), imm=-1 -> 0xFFC, valid two cycles after accept
    drive(1'b1, MEMOP_LD, 5'd7, 5'd3, 1'b0, 14'h3FFF);
    chk("ld_ready", 64'(ready_o), 64'd1);
    chk("ld_rden", 64'(regReadEn_o), 64'd1);
    chk("ld_rdaddr", 64'(regReadAddr_o), 64'd3);
    step(); idle();
    chk("ld_c1_valid", 64'(valid_o), 64'd0);
    chk("ld_c1_ready", 64'(ready_o), 64'd0);
    step();
    chk("ld_c2_valid", 64'(valid_o), 64'd1);
    chk("ld_addr", addr_o, 64'h0FFC);
    chk("ld_upd", 64'(updateEn_o), 64'd0);
    chk("ld_rt", 64'(rt_o), 64'd7);
    chk("ld_memop", 64'(memOp_o), 64'(MEMOP_LD));
    chk("ld_align", 64'(alignFault_o), 64'(ALIGN));
    step();
    chk("ld_c3_valid", 64'(valid_o), 64'd0);
    chk("ld_c3_align", 64'(alignFault_o), 64'd0);

    // STDU RA=5 (-8), imm=2 -> wraps to 0
    drive(1'b1, MEMOP_STDU, 5'd9, 5'd5, 1'b0, 14'd2);
    chk("stdu_rden", 64'(regReadEn_o), 64'd1);
    step(); idle(); step();
    chk("stdu_valid", 64'(valid_o), 64'd1);
    chk("stdu_addr", addr_o, 64'h0);
    chk("stdu_upd", 64'(updateEn_o), 64'd1);
    chk("stdu_updreg", 64'(updateReg_o), 64'd5);
    chk("stdu_align", 64'(alignFault_o), 64'd0);
    step();

    // LWA with literal-zero base, imm=4 -> 0x10, no register read
    base_cnt = rd_cnt;
    drive(1'b1, MEMOP_LWA, 5'd11, 5'd0, 1'b1, 14'd4);
    chk("lwa_rden", 64'(regReadEn_o), 64'd0);
    step(); idle(); step();
    chk("lwa_valid", 64'(valid_o), 64'd1);
    chk("lwa_addr", addr_o, 64'h10);
    chk("lwa_upd", 64'(updateEn_o), 64'd0);
    chk("lwa_noread", 64'(rd_cnt - base_cnt), 64'd0);
    step();

    // Illegal ops: LDU RA=0, XO=3, LDU RA==RT
    base_cnt = err_cnt;
    drive(1'b1, MEMOP_LDU, 5'd4, 5'd0, 1'b0, 14'd8);
    chk("ill1_ready", 64'(ready_o), 64'd1);
    chk("ill1_rden", 64'(regReadEn_o), 64'd0);
    step(); idle();
    chk("ill1_err", 64'(err_o), 64'd1);
    chk("ill1_valid", 64'(valid_o), 64'd0);
    chk("ill1_ready2", 64'(ready_o), 64'd1);
    step();
    chk("ill1_err_end", 64'(err_o), 64'd0);
    drive(1'b1, 3'b011, 5'd2, 5'd6, 1'b0, 14'd0);
    chk("ill2_ready", 64'(ready_o), 64'd1);
    step(); idle();
    chk("ill2_err", 64'(err_o), 64'd1);
    chk("ill2_valid", 64'(valid_o), 64'd0);
    step();
    chk("ill2_err_end", 64'(err_o), 64'd0);
    drive(1'b1, MEMOP_LDU, 5'd7, 5'd7, 1'b0, 14'd0);
    step(); idle();
    chk("ill3_err", 64'(err_o), 64'd1);
    step();
    chk("ill3_err_end", 64'(err_o), 64'd0);
    chk("ill3_valid", 64'(valid_o), 64'd0);
    chk("ill_err_count", 64'(err_cnt - base_cnt), 64'd3);

    // STDU with RA==RT is legal
    drive(1'b1, MEMOP_STDU, 5'd5, 5'd5, 1'b0, 14'd0);
    step(); idle(); step();
    chk("stdu_rt_valid", 64'(valid_o), 64'd1);
    chk("stdu_rt_addr", addr_o, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("stdu_rt_err", 64'(err_o), 64'd0);
    step();

    // Back-to-back with a 3-cycle downstream stall
    base_cnt = hs_cnt;
    drive(1'b1, MEMOP_LD, 5'd1, 5'd3, 1'b0, 14'd1);
    chk("b2b_a_rden", 64'(regReadEn_o), 64'd1);
    step();
    ready_i = 1'b0;
    drive(1'b1, MEMOP_STD, 5'd2, 5'd5, 1'b0, 14'd1);
    chk("b2b_read_ready", 64'(ready_o), 64'd0);
    chk("b2b_read_rden", 64'(regReadEn_o), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("b2b_hold_valid", 64'(valid_o), 64'd1);
      chk("b2b_hold_addr", addr_o, 64'h1004);
      chk("b2b_hold_rt", 64'(rt_o), 64'd1);
      chk("b2b_hold_align", 64'(alignFault_o), 64'(ALIGN));
      chk("b2b_hold_ready", 64'(ready_o), 64'd0);
    end
    step();
    chk("b2b_a_still", 64'(valid_o), 64'd1);
    ready_i = 1'b1;
    #1;
    chk("b2b_b_ready", 64'(ready_o), 64'd1);
    chk("b2b_b_rden", 64'(regReadEn_o), 64'd1);
    chk("b2b_b_rdaddr", 64'(regReadAddr_o), 64'd5);
    step(); idle();
    chk("b2b_b_read", 64'(valid_o), 64'd0);
    step();
    chk("b2b_b_valid", 64'(valid_o), 64'd1);
    chk("b2b_b_addr", addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("b2b_b_rt", 64'(rt_o), 64'd2);
    chk("b2b_b_memop", 64'(memOp_o), 64'(MEMOP_STD));
    chk("b2b_b_align", 64'(alignFault_o), 64'(ALIGN));
    step();
    chk("b2b_end_valid", 64'(valid_o), 64'd0);
    chk("b2b_handshakes", 64'(hs_cnt - base_cnt), 64'd2);

    // Reset asserted mid-READ discards the op
    base_cnt = hs_cnt;
    drive(1'b1, MEMOP_LD, 5'd1, 5'd3, 1'b0, 14'd0);
    step(); idle();
    reset_n_i = 1'b0;
    #1;
    chk("rmid_valid", 64'(valid_o), 64'd0);
    chk("rmid_rden", 64'(regReadEn_o), 64'd0);
    chk("rmid_addr", addr_o, 64'd0);
    chk("rmid_rt", 64'(rt_o), 64'd0);
    step();
    reset_n_i = 1'b1;
    #1;
    chk("rmid_ready", 64'(ready_o), 64'd1);
    step(); step();
    chk("rmid_discard", 64'(valid_o), 64'd0);
    chk("rmid_no_hs", 64'(hs_cnt - base_cnt), 64'd0);

    // STQ at 0x1008: quadword misaligned
    drive(1'b1, MEMOP_STQ, 5'd8, 5'd3, 1'b0, 14'd2);
    step(); idle(); step();
    chk("stq_valid", 64'(valid_o), 64'd1);
    chk("stq_addr", addr_o, 64'h1008);
    chk("stq_memop", 64'(memOp_o), 64'(MEMOP_STQ));
    chk("stq_align", 64'(alignFault_o), 64'(ALIGN));
    step();
    chk("stq_end_valid", 64'(valid_o), 64'd0);
    chk("stq_end_align", 64'(alignFault_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ds_agen_stage.md
DS_AGEN_STAGE -- requirements
Module: ds_agen_stage

Interface
REQ-001 SHALL have ports: clock_i  in  1  sole clock, rising edge; reset_n_i  in  1  asynchronous, active-low reset.
REQ-002 SHALL have upstream ports: enable_i  in  1  decoded DS op valid; ready_o  out  1  stage can accept.
REQ-003 SHALL have decoded-field inputs:
  - reg1_i  in  5  RT/RS.
  - reg2_i  in  5  RA.
  - reg2ValOrZero_i  in  1  RA==0 means literal zero.
  - imm_i  in  14  DS field.
  - memOp_i  in  3  {isStore, XO[30:31]}.
REQ-004 SHALL have register-file read ports: regReadEn_o  out  1; regReadAddr_o  out  5; regReadData_i  in  64, valid one cycle after regReadEn_o.
REQ-005 SHALL have downstream ports:
  - valid_o  out  1.
  - ready_i  in  1.
  - addr_o  out  64  effective address.
  - rt_o  out  5.
  - memOp_o  out  3.
  - updateEn_o  out  1.
  - updateReg_o  out  5.
  - alignFault_o  out  1.
  - err_o  out  1  one-cycle pulse.

Function
REQ-006 SHALL implement FSM IDLE -> READ -> VALID.
  - IDLE->READ when enable_i && ready_o && op legal.
  - READ->VALID unconditionally.
  - VALID->IDLE when ready_i and no new accept.
  - VALID->READ when ready_i and a new legal accept occurs in the same cycle.
REQ-007 SHALL drive ready_o = (state==IDLE) || (state==VALID && ready_i).
REQ-008 SHALL latch all decoded fields on accept; inputs are ignored while ready_o==0.
REQ-009 SHALL, on accept, assert regReadEn_o for exactly one cycle with regReadAddr_o=reg2_i, unless reg2ValOrZero_i==1 && reg2_i==0, in which case regReadEn_o=0 and base=0.
REQ-010 SHALL compute in READ: addr_o = base + signext64({imm, 2'b00}), modulo 2^64, with no overflow flag.
REQ-011 SHALL have a fixed latency of 2 cycles from accept to valid_o, including the zero-base case.
REQ-012 SHALL hold valid_o and all output fields stable while valid_o && !ready_i.
REQ-013 SHALL, for update forms (XO=1, load or store), drive updateEn_o=1 and updateReg_o=RA; otherwise updateEn_o=0.
REQ-014 SHALL treat as illegal:
  - XO=3.
  - Update form with RA==0.
  - Load update with RA==RT.
  - Illegal ops are consumed (ready_o honoured), produce no valid_o, and pulse err_o one cycle after accept.
REQ-015 SHALL pass rt_o=reg1_i and memOp_o=memOp_i unchanged.
REQ-016 SHALL drive err_o=0 and alignFault_o=0 whenever valid_o=0 (except the err_o pulse in REQ-014).

Reset
REQ-017 SHALL force, on reset_n_i low, regardless of clock:
  - state=IDLE.
  - valid_o, regReadEn_o, updateEn_o, alignFault_o, err_o = 0.
  - addr_o, rt_o, memOp_o, updateReg_o, regReadAddr_o = 0.
REQ-018 SHALL discard any in-flight op on reset mid-operation; after reset deassertion, ready_o=1 on the first clock.

Configuration
REQ-019 SHALL, with DS_AGEN_ALIGN_CHECK_EN defined:
  - Set alignFault_o with valid_o when addr_o[61:63]!=0 for doubleword/word ops.
  - Set alignFault_o with valid_o when addr_o[60:63]!=0 for quadword store (memOp 3'b110).
  - The op is still delivered.
REQ-020 SHALL, without DS_AGEN_ALIGN_CHECK_EN, tie alignFault_o to 0 and omit the check logic.

Structure
REQ-021 SHALL place the following in a shared package (ds_mem_pkg):
  - memOp encodings: LD=3'b000, LDU=3'b001, LWA=3'b010, STD=3'b100, STDU=3'b101, STQ=3'b110.
  - FSM state typedef.
  - Width constants: 64/14/5.
REQ-022 SHALL isolate EA add and alignment check in one combinational sub-module, ds_ea_calc.

Verification
REQ-023 SHALL cover: LD, RA=3 holding 0x1000, imm=0x3FFF (-1) -> addr_o=0x0FFC, valid_o at cycle 2, updateEn_o=0.
REQ-024 SHALL cover: STDU, RA=5 holding 0xFFFF_FFFF_FFFF_FFF8, imm=2 -> addr_o=0x0 (wrap), updateEn_o=1, updateReg_o=5.
REQ-025 SHALL cover: LWA, RA=0, reg2ValOrZero_i=1, imm=4 -> regReadEn_o never asserted, addr_o=0x10.
REQ-026 SHALL cover: LDU with RA=0, and a separate op with XO=3 -> no valid_o, err_o pulses once per op, ready_o stays 1.
REQ-027 SHALL cover: back-to-back ops with ready_i low for 3 cycles -> outputs held stable, no op lost or duplicated; reset_n_i asserted mid-READ -> valid_o=0 immediately.
REQ-028 SHALL cover, with DS_AGEN_ALIGN_CHECK_EN: STQ at EA 0x1008 -> alignFault_o=1; without the macro, the same stimulus -> alignFault_o=0.
